// File: rtl/serial_port_device.sv
// serial_port_device: device-side endpoint of the processor serial interface.
// Processor bytes are buffered in a TX FIFO and sent as 8N1 UART frames.
// Received frames land in a first-word-fall-through RX FIFO.
// Build option: define SERIAL_PORT_LOOPBACK_EN to feed the receiver from the
// internal uart_tx instead of the uart_rx pin. The uart_tx pin stays driven.
module serial_port_device #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] proc_wdata,
  input  logic       proc_wren,
  output logic       proc_wready,
  output logic [7:0] proc_rdata,
  output logic       proc_rvalid,
  input  logic       proc_rden,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_overrun,
  output logic       rx_frame_err
);
  localparam int unsigned AW   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNTW = AW + 1;
  localparam int unsigned CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]   BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0]   HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNTW-1:0] FULL_CNT  = CNTW'(FIFO_DEPTH);

  // ---------------- TX FIFO ----------------
  logic [7:0]      tx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   tx_wptr_q, tx_rptr_q;
  logic [CNTW-1:0] tx_count_q;
  logic            tx_push, tx_pop, tx_avail;

  assign proc_wready = (tx_count_q != FULL_CNT);
  assign tx_push     = proc_wren & proc_wready;
  assign tx_avail    = (tx_count_q != '0);

  // TX storage: written only on accepted processor pushes
  always_ff @(posedge clock) begin
    if (tx_push) tx_mem_q[tx_wptr_q] <= proc_wdata;
  end

  // TX pointers and occupancy
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_wptr_q  <= '0;
      tx_rptr_q  <= '0;
      tx_count_q <= '0;
    end else begin
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      if (tx_push && !tx_pop)      tx_count_q <= tx_count_q + 1'b1;
      else if (!tx_push && tx_pop) tx_count_q <= tx_count_q - 1'b1;
    end
  end

  // ---------------- TX serialiser ----------------
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  tx_state_e     tx_state_q, tx_state_d;
  logic [CW-1:0] tx_cnt_q, tx_cnt_d;
  logic [2:0]    tx_bit_q, tx_bit_d;
  logic [7:0]    tx_shift_q, tx_shift_d;
  logic          tx_line_q, tx_line_d;

  // TX state register; the line is registered so it returns high on reset
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_line_q  <= 1'b1;
    end else begin
      tx_state_q <= tx_state_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_bit_q   <= tx_bit_d;
      tx_shift_q <= tx_shift_d;
      tx_line_q  <= tx_line_d;
    end
  end

  // TX next state; STOP pops the next byte directly so frames run back-to-back
  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_shift_d = tx_shift_q;
    tx_line_d  = 1'b1;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (tx_avail) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_mem_q[tx_rptr_q];
          tx_cnt_d   = '0;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        tx_line_d = 1'b0;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_bit_d   = '0;
          tx_state_d = TX_DATA;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_DATA: begin
        tx_line_d = tx_shift_q[0];
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d   = '0;
          tx_shift_d = {1'b0, tx_shift_q[7:1]};
          if (tx_bit_q == 3'd7) tx_state_d = TX_STOP;
          else                  tx_bit_d   = tx_bit_q + 1'b1;
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      TX_STOP: begin
        tx_line_d = 1'b1;
        if (tx_cnt_q == BIT_LAST) begin
          tx_cnt_d = '0;
          if (tx_avail) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_mem_q[tx_rptr_q];
            tx_state_d = TX_START;
          end else begin
            tx_state_d = TX_IDLE;
          end
        end else begin
          tx_cnt_d = tx_cnt_q + 1'b1;
        end
      end
      default: tx_state_d = TX_IDLE;
    endcase
  end

  assign uart_tx = tx_line_q;

  // ---------------- RX input select and synchroniser ----------------
  logic rx_src;
`ifdef SERIAL_PORT_LOOPBACK_EN
  logic unused_uart_rx;
  assign unused_uart_rx = uart_rx;
  assign rx_src         = tx_line_q;
`else
  assign rx_src = uart_rx;
`endif

  logic rx_sync1_q, rx_sync2_q, rx_prev_q;

  // Two-flop synchroniser plus previous sample for falling-edge detect
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_sync1_q <= 1'b1;
      rx_sync2_q <= 1'b1;
      rx_prev_q  <= 1'b1;
    end else begin
      rx_sync1_q <= rx_src;
      rx_sync2_q <= rx_sync1_q;
      rx_prev_q  <= rx_sync2_q;
    end
  end

  // ---------------- RX deserialiser ----------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  rx_state_e     rx_state_q, rx_state_d;
  logic [CW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]    rx_bit_q, rx_bit_d;
  logic [7:0]    rx_shift_q, rx_shift_d;
  logic          rx_push, rx_ferr;

  // RX state register
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
    end else begin
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_shift_q <= rx_shift_d;
    end
  end

  // RX next state; edge detect needs a high sample first, so a low line after a bad stop is ignored
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_push    = 1'b0;
    rx_ferr    = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_prev_q && !rx_sync2_q) begin
          rx_cnt_d   = '0;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == HALF_LAST) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_sync2_q, rx_shift_q[7:1]};
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
          else                  rx_bit_d   = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == BIT_LAST) begin
          rx_cnt_d   = '0;
          rx_push    = rx_sync2_q;
          rx_ferr    = !rx_sync2_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // ---------------- RX FIFO ----------------
  logic [7:0]      rx_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   rx_wptr_q, rx_rptr_q;
  logic [CNTW-1:0] rx_count_q;
  logic            rx_pop, rx_accept;
  logic            rx_overrun_q, rx_frame_err_q;

  assign proc_rvalid = (rx_count_q != '0);
  assign proc_rdata  = proc_rvalid ? rx_mem_q[rx_rptr_q] : '0;
  assign rx_pop      = proc_rden & proc_rvalid;
  // A same-cycle pop frees the slot, so a full FIFO still accepts
  assign rx_accept   = rx_push & ((rx_count_q != FULL_CNT) | rx_pop);

  // RX storage
  always_ff @(posedge clock) begin
    if (rx_accept) rx_mem_q[rx_wptr_q] <= rx_shift_q;
  end

  // RX pointers, occupancy and sticky error flags
  always_ff @(posedge clock) begin
    if (reset) begin
      rx_wptr_q      <= '0;
      rx_rptr_q      <= '0;
      rx_count_q     <= '0;
      rx_overrun_q   <= 1'b0;
      rx_frame_err_q <= 1'b0;
    end else begin
      if (rx_accept) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)    rx_rptr_q <= rx_rptr_q + 1'b1;
      if (rx_accept && !rx_pop)      rx_count_q <= rx_count_q + 1'b1;
      else if (!rx_accept && rx_pop) rx_count_q <= rx_count_q - 1'b1;
      if (rx_push && !rx_accept) rx_overrun_q   <= 1'b1;
      if (rx_ferr)               rx_frame_err_q <= 1'b1;
    end
  end

  assign rx_overrun   = rx_overrun_q;
  assign rx_frame_err = rx_frame_err_q;

endmodule

// File: tb/tb_serial_port_device.sv
// Scoreboard bench for serial_port_device (CLKS_PER_BIT=8, FIFO_DEPTH=4).
// A UART decoder watches uart_tx and a reader drains the RX FIFO; both pop
// expected values pushed by the stimulus process.
module tb_serial_port_device;
  localparam int unsigned CPB   = 8;
  localparam int unsigned DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] proc_wdata = '0;
  logic       proc_wren = 1'b0;
  logic       proc_wready;
  logic [7:0] proc_rdata;
  logic       proc_rvalid;
  logic       proc_rden = 1'b0;
  logic       uart_rx = 1'b1;
  logic       uart_tx;
  logic       rx_overrun;
  logic       rx_frame_err;

  always #5 clock = ~clock;

  serial_port_device #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock       (clock),
    .reset       (reset),
    .proc_wdata  (proc_wdata),
    .proc_wren   (proc_wren),
    .proc_wready (proc_wready),
    .proc_rdata  (proc_rdata),
    .proc_rvalid (proc_rvalid),
    .proc_rden   (proc_rden),
    .uart_rx     (uart_rx),
    .uart_tx     (uart_tx),
    .rx_overrun  (rx_overrun),
    .rx_frame_err(rx_frame_err)
  );

  typedef struct {
    logic [7:0] data;
    bit         b2b;   // frame must start exactly one frame time after the previous one
  } tx_exp_t;

  tx_exp_t    exp_tx[$];
  logic [7:0] exp_rx[$];
  int n_checks  = 0;
  int n_fail    = 0;
  int cyc       = 0;
  int reset_cyc = 0;
  bit rd_en     = 1'b1;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] d, input bit accept, input bit b2b);
    tx_exp_t e;
    e.data = d;
    e.b2b  = b2b;
    proc_wdata = d;
    proc_wren  = 1'b1;
    if (accept) begin
      exp_tx.push_back(e);
`ifdef SERIAL_PORT_LOOPBACK_EN
      exp_rx.push_back(d);
`endif
    end
    tick(1);
    proc_wren = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    uart_rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      uart_rx = d[i];
      tick(CPB);
    end
    uart_rx = stop;
    tick(CPB);
    uart_rx = 1'b1;
    tick(4);
  endtask

  task automatic wait_drain(input int limit);
    int k = 0;
    while ((exp_tx.size() != 0 || exp_rx.size() != 0) && k < limit) begin
      tick(1);
      k++;
    end
    check("drain_tx", exp_tx.size(), 0);
    check("drain_rx", exp_rx.size(), 0);
  endtask

  // UART decoder on uart_tx: samples each bit at its centre
  initial begin : tx_mon
    int         start;
    int         prev_start;
    logic [7:0] data;
    logic       sbit, stop;
    tx_exp_t    e;
    prev_start = 0;
    forever begin
      @(negedge clock);
      if (!reset && uart_tx === 1'b0) begin
        start = cyc;
        repeat (CPB / 2) @(negedge clock);
        sbit = uart_tx;
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clock);
          data[i] = uart_tx;
        end
        repeat (CPB) @(negedge clock);
        stop = uart_tx;
        if (start < reset_cyc) continue;
        if (exp_tx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL tx_unexpected_frame: got 0x%0h, expected no frame", data);
        end else begin
          e = exp_tx.pop_front();
          check("tx_start_bit", sbit, 0);
          check("tx_data", data, e.data);
          check("tx_stop_bit", stop, 1);
          if (e.b2b) check("tx_frame_gap", start - prev_start, FRAME);
        end
        prev_start = start;
      end
    end
  end

  // Processor-side reader: pops whenever enabled and data is presented
  initial begin : rx_mon
    forever begin
      @(negedge clock);
      if (rd_en && !reset && proc_rvalid === 1'b1) begin
        if (exp_rx.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rx_unexpected_byte: got 0x%0h, expected none", proc_rdata);
        end else begin
          check("rx_data", proc_rdata, exp_rx.pop_front());
        end
        proc_rden = 1'b1;
      end else begin
        proc_rden = 1'b0;
      end
    end
  end

  initial begin : stim
    logic [7:0] d;
    int         occ;
    reset = 1'b1;
    tick(3);
    check("rst_uart_tx", uart_tx, 1);
    check("rst_wready", proc_wready, 1);
    check("rst_rvalid", proc_rvalid, 0);
    check("rst_rdata", proc_rdata, 0);
    check("rst_overrun", rx_overrun, 0);
    check("rst_frame_err", rx_frame_err, 0);
    reset = 1'b0;
    tick(2);

    // Single write on idle: start bit appears two clocks after the write edge
    write_byte(8'h55, 1, 0);
    check("tx_high_after_write", uart_tx, 1);
    check("wready_after_one", proc_wready, 1);
    tick(1);
    check("tx_high_one_cycle", uart_tx, 1);
    tick(1);
    check("tx_start_latency", uart_tx, 0);
    wait_drain(FRAME + 40);
    tick(10);

    // Busy transmitter, then five back-to-back writes: four fit, fifth dropped
    write_byte(8'($urandom), 1, 0);
    tick(5);
    occ = 0;
    for (int i = 0; i < 5; i++) begin
      check("wready_before_write", proc_wready, (occ < DEPTH) ? 1 : 0);
      write_byte(8'($urandom), occ < DEPTH, 1);
      if (occ < DEPTH) occ++;
    end
    check("wready_low_when_full", proc_wready, 0);
    wait_drain(6 * FRAME);
    tick(10);

`ifdef SERIAL_PORT_LOOPBACK_EN
    // Loopback: written byte returns on the read side within one frame
    rd_en = 1'b0;
    write_byte(8'hC7, 1, 0);
    begin
      int k = 0;
      while (proc_rvalid !== 1'b1 && k < 84) begin
        tick(1);
        k++;
      end
    end
    check("lb_rvalid", proc_rvalid, 1);
    check("lb_rdata", proc_rdata, 8'hC7);
    rd_en = 1'b1;
    wait_drain(2 * FRAME);
`else
    // Single received byte held until popped
    rd_en = 1'b0;
    exp_rx.push_back(8'hA3);
    send_frame(8'hA3, 1);
    check("rx_rvalid_a3", proc_rvalid, 1);
    check("rx_rdata_a3", proc_rdata, 8'hA3);
    rd_en = 1'b1;
    tick(3);
    check("rx_rvalid_after_pop", proc_rvalid, 0);
    check("rx_rdata_empty", proc_rdata, 0);

    // Short low glitch is a false start
    uart_rx = 1'b0;
    tick(3);
    uart_rx = 1'b1;
    tick(20);
    check("glitch_no_push", proc_rvalid, 0);
    check("glitch_no_ferr", rx_frame_err, 0);

    // Low stop bit: byte discarded, sticky error
    send_frame(8'($urandom), 0);
    tick(4);
    check("ferr_set", rx_frame_err, 1);
    check("ferr_no_push", proc_rvalid, 0);

    // Random frames with the reader draining
    for (int i = 0; i < 6; i++) begin
      d = 8'($urandom);
      exp_rx.push_back(d);
      send_frame(d, 1);
      tick($urandom_range(0, 5));
    end
    wait_drain(50);

    // Five frames unread: first four kept in order, fifth overruns
    rd_en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i == DEPTH) check("overrun_clear_at_full", rx_overrun, 0);
      d = 8'($urandom);
      if (i < DEPTH) exp_rx.push_back(d);
      send_frame(d, 1);
    end
    check("overrun_set", rx_overrun, 1);
    check("overrun_rvalid", proc_rvalid, 1);
    rd_en = 1'b1;
    wait_drain(50);
    tick(3);
    check("overrun_drained", proc_rvalid, 0);
`endif

    // Reset in the middle of a frame with bytes still queued
    write_byte(8'($urandom), 1, 0);
    write_byte(8'($urandom), 1, 1);
    write_byte(8'($urandom), 1, 1);
    tick(30);
    reset     = 1'b1;
    reset_cyc = cyc;
    exp_tx.delete();
    exp_rx.delete();
    tick(1);
    check("midrst_uart_tx", uart_tx, 1);
    check("midrst_wready", proc_wready, 1);
    check("midrst_rvalid", proc_rvalid, 0);
    check("midrst_rdata", proc_rdata, 0);
    check("midrst_overrun", rx_overrun, 0);
    check("midrst_frame_err", rx_frame_err, 0);
    reset = 1'b0;
    tick(100);
    check("post_rst_line_idle", uart_tx, 1);
    write_byte(8'($urandom), 1, 0);
    wait_drain(2 * FRAME);
    tick(2 * FRAME);
    check("post_rst_no_extra", exp_tx.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
